// File: rtl/console_pkg.sv
// Control codes, default blank code and controller states for the text console writer.
package console_pkg;

   localparam logic [7:0] CH_BS          = 8'h08;
   localparam logic [7:0] CH_LF          = 8'h0A;
   localparam logic [7:0] CH_FF          = 8'h0C;
   localparam logic [7:0] CH_CR          = 8'h0D;
   localparam logic [7:0] DEF_BLANK_CHAR = 8'h20;

   typedef enum logic [1:0] {
      CLEAR_ALL,
      IDLE,
      CLEAR_LINE
   } state_t;

endpackage

// File: rtl/text_console_writer.sv
// Producer side of the text-mode video path: consumes a byte stream, tracks the
// cursor and writes character codes into the external dual-port character RAM.
module text_console_writer
   import console_pkg::*;
#(
   parameter int unsigned                      COLS       = 160,
   parameter int unsigned                      ROWS       = 45,
   parameter int unsigned                      NUM_CHAR   = 256,
   parameter logic [$clog2(NUM_CHAR)-1:0]      BLANK_CHAR = DEF_BLANK_CHAR
)(
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic [$clog2(NUM_CHAR)-1:0]      i_data,
   input  logic                             i_valid,
   output logic                             o_ready,
   output logic                             o_wr_en,
   output logic [$clog2(COLS*ROWS)-1:0]     o_wr_addr,
   output logic [$clog2(NUM_CHAR)-1:0]      o_wr_data,
   output logic [$clog2(COLS)-1:0]          o_cursor_col,
   output logic [$clog2(ROWS)-1:0]          o_cursor_row,
   output logic                             o_busy
);

   localparam int unsigned DW = $clog2(NUM_CHAR);
   localparam int unsigned AW = $clog2(COLS*ROWS);
   localparam int unsigned CW = $clog2(COLS);
   localparam int unsigned RW = $clog2(ROWS);

   localparam logic [AW-1:0] LAST_ADDR = AW'(COLS*ROWS-1);
   localparam logic [AW-1:0] COLS_A    = AW'(COLS);
   localparam logic [CW-1:0] LAST_COL  = CW'(COLS-1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS-1);

   localparam logic [DW-1:0] W_BS = DW'(CH_BS);
   localparam logic [DW-1:0] W_LF = DW'(CH_LF);
   localparam logic [DW-1:0] W_FF = DW'(CH_FF);
   localparam logic [DW-1:0] W_CR = DW'(CH_CR);

   state_t          r_state;
   logic            r_started;
   logic [CW-1:0]   r_col;
   logic [RW-1:0]   r_row;
   logic [AW-1:0]   r_row_base;
   logic [AW-1:0]   r_clr_addr;
   logic [AW-1:0]   r_clr_end;
   logic            r_wr_en;
   logic [AW-1:0]   r_wr_addr;
   logic [DW-1:0]   r_wr_data;

   logic            w_last_row;
   logic [RW-1:0]   w_next_row;
   logic [AW-1:0]   w_next_base;
   logic [AW-1:0]   w_cur_addr;

   // Next-row position and RAM address of the cursor; row_base replaces row*COLS.
   always_comb begin
      w_last_row  = (r_row == LAST_ROW);
      w_next_row  = w_last_row ? '0 : r_row + RW'(1);
      w_next_base = w_last_row ? '0 : r_row_base + COLS_A;
      w_cur_addr  = r_row_base + AW'(r_col);
   end

   // Controller: clear sequencing, byte decoding, cursor tracking and registered write port.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= CLEAR_ALL;
         r_started  <= 1'b0;
         r_col      <= '0;
         r_row      <= '0;
         r_row_base <= '0;
         r_clr_addr <= '0;
         r_clr_end  <= LAST_ADDR;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_started <= 1'b1;
         r_wr_en   <= 1'b0;
         case (r_state)
            CLEAR_ALL: begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_clr_addr;
               r_wr_data <= BLANK_CHAR;
               if (r_clr_addr == r_clr_end) begin
                  r_state    <= IDLE;
                  r_col      <= '0;
                  r_row      <= '0;
                  r_row_base <= '0;
               end else begin
                  r_clr_addr <= r_clr_addr + AW'(1);
               end
            end
            CLEAR_LINE: begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_clr_addr;
               r_wr_data <= BLANK_CHAR;
               if (r_clr_addr == r_clr_end) begin
                  r_state <= IDLE;
               end else begin
                  r_clr_addr <= r_clr_addr + AW'(1);
               end
            end
            IDLE: begin
               if (i_valid) begin
                  case (i_data)
                     W_LF: begin
                        r_col      <= '0;
                        r_row      <= w_next_row;
                        r_row_base <= w_next_base;
                        r_clr_addr <= w_next_base;
                        r_clr_end  <= w_next_base + COLS_A - AW'(1);
                        r_state    <= CLEAR_LINE;
                     end
                     W_CR: begin
                        r_col <= '0;
                     end
                     W_BS: begin
                        if (r_col != '0) begin
                           r_col     <= r_col - CW'(1);
                           r_wr_en   <= 1'b1;
                           r_wr_addr <= w_cur_addr - AW'(1);
                           r_wr_data <= BLANK_CHAR;
                        end
                     end
                     W_FF: begin
                        r_clr_addr <= '0;
                        r_clr_end  <= LAST_ADDR;
                        r_state    <= CLEAR_ALL;
                     end
                     default: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_cur_addr;
                        r_wr_data <= i_data;
                        if (r_col == LAST_COL) begin
                           r_col      <= '0;
                           r_row      <= w_next_row;
                           r_row_base <= w_next_base;
                           r_clr_addr <= w_next_base;
                           r_clr_end  <= w_next_base + COLS_A - AW'(1);
                           r_state    <= CLEAR_LINE;
                        end else begin
                           r_col <= r_col + CW'(1);
                        end
                     end
                  endcase
               end
            end
            default: begin
               r_state    <= CLEAR_ALL;
               r_clr_addr <= '0;
               r_clr_end  <= LAST_ADDR;
            end
         endcase
      end
   end

   assign o_ready      = (r_state == IDLE);
   assign o_busy       = r_started && (r_state != IDLE);
   assign o_wr_en      = r_wr_en;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_data    = r_wr_data;
   assign o_cursor_col = r_col;
   assign o_cursor_row = r_row;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: a behavioural screen model predicts
// the stream of RAM writes, the cursor and the stall length after every byte.
`timescale 1ns/1ps
module tb_text_console_writer;

   localparam int COLS  = 160;
   localparam int ROWS  = 45;
   localparam int NCELL = COLS * ROWS;
   localparam int BOUND = 20000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  i_data = '0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic        o_wr_en;
   logic [12:0] o_wr_addr;
   logic [7:0]  o_wr_data;
   logic [7:0]  o_cursor_col;
   logic [5:0]  o_cursor_row;
   logic        o_busy;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int  m_row = 0;
   int  m_col = 0;
   int  exp_stall = 0;
   bit  exp_wr = 0;
   bit  ff_pending = 0;
   int  exp_q[$];

   text_console_writer #(
      .COLS(160), .ROWS(45), .NUM_CHAR(256), .BLANK_CHAR(8'h20)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
      .o_ready(o_ready), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
      .o_wr_data(o_wr_data), .o_cursor_col(o_cursor_col),
      .o_cursor_row(o_cursor_row), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void push_wr(int a, int d);
      exp_q.push_back(a * 256 + d);
   endfunction

   function automatic void adv_row();
      m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
      for (int i = 0; i < COLS; i++) push_wr(m_row * COLS + i, 8'h20);
      exp_stall = COLS;
   endfunction

   function automatic void push_full_clear();
      for (int i = 0; i < NCELL; i++) push_wr(i, 8'h20);
   endfunction

   function automatic void model_byte(logic [7:0] b);
      exp_wr = 0; exp_stall = 0; ff_pending = 0;
      case (b)
         8'h0A: begin m_col = 0; adv_row(); end
         8'h0D: m_col = 0;
         8'h08: if (m_col > 0) begin
            m_col--; push_wr(m_row * COLS + m_col, 8'h20); exp_wr = 1;
         end
         8'h0C: begin
            push_full_clear(); exp_stall = NCELL;
            m_row = 0; m_col = 0; ff_pending = 1;
         end
         default: begin
            push_wr(m_row * COLS + m_col, b); exp_wr = 1;
            if (m_col == COLS - 1) begin m_col = 0; adv_row(); end
            else m_col++;
         end
      endcase
   endfunction

   // Every write the DUT issues must match the next predicted write.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && o_wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("wr_unexpected", 32'(o_wr_addr), 32'hFFFF_FFFF);
         end else begin
            int e;
            e = exp_q.pop_front();
            check_eq("wr_addr", 32'(o_wr_addr), 32'(e / 256));
            check_eq("wr_data", 32'(o_wr_data), 32'(e % 256));
         end
      end
   end

   task automatic wait_ready(output int n);
      n = 0;
      while (o_ready !== 1'b1 && n < BOUND) begin n++; @(negedge clk); end
      if (o_ready !== 1'b1) check_eq("ready_timeout", 32'(o_ready), 32'd1);
   endtask

   task automatic check_cursor(input string tag);
      check_eq({tag, "_col"}, 32'(o_cursor_col), 32'(m_col));
      check_eq({tag, "_row"}, 32'(o_cursor_row), 32'(m_row));
   endtask

   task automatic send_byte(input logic [7:0] b, input bit chk_stall);
      int n;
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = b;
      n = 0;
      while (o_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
      if (o_ready !== 1'b1) begin
         check_eq("accept_timeout", 32'(o_ready), 32'd1);
         i_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_data  = 8'($urandom);
      model_byte(b);
      @(negedge clk);
      check_eq("wr_en_n1", 32'(o_wr_en), 32'(exp_wr));
      check_eq("busy_n1", 32'(o_busy), 32'(exp_stall > 0));
      if (!ff_pending) check_cursor("cur_n1");
      if (chk_stall) begin
         wait_ready(n);
         check_eq("stall_len", 32'(n), 32'(exp_stall));
         check_eq("busy_idle", 32'(o_busy), 32'd0);
         check_cursor("cur_idle");
      end
   endtask

   function automatic logic [7:0] rand_byte();
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 7)       b = 8'h0A;
      else if (r < 13) b = 8'h0D;
      else if (r < 25) b = 8'h08;
      else begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h41;
      end
      return b;
   endfunction

   initial begin
      #(5_000_000);
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset values
      #23;
      check_eq("rst_ready", 32'(o_ready), 32'd0);
      check_eq("rst_wr_en", 32'(o_wr_en), 32'd0);
      check_eq("rst_addr",  32'(o_wr_addr), 32'd0);
      check_eq("rst_data",  32'(o_wr_data), 32'd0);
      check_eq("rst_busy",  32'(o_busy), 32'd0);
      check_cursor("rst");
      push_full_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("clr_busy", 32'(o_busy), 32'd1);
      check_eq("clr_ready", 32'(o_ready), 32'd0);
      wait_ready(n);
      check_cursor("post_clr");
      @(negedge clk);
      check_eq("clr_drained", 32'(exp_q.size()), 32'd0);

      // Single char, then a full row of 'B' wrapping to row 1
      send_byte(8'h41, 1);
      send_byte(8'h0D, 1);
      for (int i = 0; i < COLS; i++) send_byte(8'h42, 1);

      // Backspace at column 0, then X, Y, BS
      send_byte(8'h08, 1);
      send_byte(8'h58, 1);
      send_byte(8'h59, 1);
      send_byte(8'h08, 1);

      // Reach (44,5) and line-feed into row 0
      send_byte(8'h0D, 1);
      while (m_row != ROWS - 1) send_byte(8'h0A, 1);
      for (int i = 0; i < 5; i++) send_byte(8'h63, 1);
      send_byte(8'h0A, 1);

      // Form feed at (10,20)
      while (m_row != 10) send_byte(8'h0A, 1);
      for (int i = 0; i < 20; i++) send_byte(8'h66, 1);
      send_byte(8'h0C, 1);

      // Valid held high while a line clear is running
      send_byte(8'h0A, 0);
      send_byte(8'h51, 1);

      // Random traffic
      for (int i = 0; i < 300; i++) send_byte(rand_byte(), 1);

      // Reset asserted in the middle of a line clear
      send_byte(8'h0A, 0);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_wr_en", 32'(o_wr_en), 32'd0);
      check_eq("mid_rst_ready", 32'(o_ready), 32'd0);
      check_eq("mid_rst_busy",  32'(o_busy), 32'd0);
      exp_q.delete();
      m_row = 0; m_col = 0;
      check_cursor("mid_rst");
      push_full_clear();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("reclr_busy", 32'(o_busy), 32'd1);
      wait_ready(n);
      check_cursor("post_reclr");
      for (int i = 0; i < 20; i++) send_byte(rand_byte(), 1);

      @(negedge clk);
      @(negedge clk);
      check_eq("wr_pending", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Producer side of the text-mode video path. Accepts a byte stream (ASCII plus a few control codes) over a valid/ready handshake.
- Tracks a cursor and writes character codes into an external dual-port character RAM. The glyph/pixel renderer reads the other port of that RAM.
- Handles line wrap, wrap-to-top of screen, line clearing and full-screen clear.

Parameters:
- COLS, 160, characters per row (1280 px / 8 px glyph width)
- ROWS, 45, character rows (720 px / 16 px glyph height)
- NUM_CHAR, 256, glyph count; sets character code width $clog2(NUM_CHAR)
- BLANK_CHAR, 8'h20, code written when clearing

Ports:
- i_clk  input  1  system/pixel clock, sole clock
- i_rst_n  input  1  asynchronous active-low reset
- i_data  input  $clog2(NUM_CHAR)  incoming byte
- i_valid  input  1  i_data valid
- o_ready  output  1  block can accept a byte this cycle
- o_wr_en  output  1  character RAM write strobe
- o_wr_addr  output  $clog2(COLS*ROWS)  RAM address = row*COLS + col
- o_wr_data  output  $clog2(NUM_CHAR)  character code to write
- o_cursor_col  output  $clog2(COLS)  current cursor column
- o_cursor_row  output  $clog2(ROWS)  current cursor row
- o_busy  output  1  high while a clear sequence runs

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: o_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, cursor=(0,0), o_busy=0. State = CLEAR_ALL on the first clock after deassertion.
- Reset mid-operation: aborts everything immediately (o_wr_en drops asynchronously) and restarts CLEAR_ALL.
- States:
  - CLEAR_ALL: writes BLANK_CHAR to addresses 0..COLS*ROWS-1, one per cycle, ascending. Then goes to IDLE with cursor (0,0).
  - IDLE: o_ready=1.
  - CLEAR_LINE: writes BLANK_CHAR to row_base..row_base+COLS-1 for the current cursor row. Then goes to IDLE.
- o_ready = (state==IDLE), decoded combinationally from the state register. o_busy = (state != IDLE) after the post-reset cycle.
- Handshake: a byte is accepted when i_valid && o_ready. i_data is sampled only on that edge. Holding i_valid with no handshake has no effect.
- Latency: byte accepted at edge N → write outputs and cursor update are registered and visible from N+1. o_wr_en is high for exactly one cycle per write.
- Byte decoding in IDLE:
  - 0x0A (LF): col=0, advance row; no character write.
  - 0x0D (CR): col=0; no write.
  - 0x08 (BS):
    - col>0: col=col-1 and BLANK_CHAR is written at the new position.
    - col==0: no write, no cursor change.
  - 0x0C (FF): enter CLEAR_ALL; cursor returns to (0,0) when it completes.
  - Any other byte: write it at (row,col), then advance col.
    - If col was COLS-1: col=0 and advance row.
- Advance row:
  - row<ROWS-1: row+1.
  - row==ROWS-1: row=0 (wrap, no scrolling).
  - In both cases enter CLEAR_LINE for the new row, starting the cycle after acceptance. o_ready stays low for exactly COLS cycles.
- Arithmetic:
  - No multiplier. A row_base register tracks row*COLS: +COLS on row advance, 0 on wrap.
  - o_wr_addr = row_base + col, computed at address width.
  - Column and row counters never exceed COLS-1 / ROWS-1.
- Printable char at (ROWS-1, COLS-1): the char is written at the last address, the cursor becomes (0,0), and row 0 is cleared.
- Only one write is issued per cycle, so a character write and a clear write never occur on the same cycle.

Decomposition:
- Package console_pkg holds:
  - control-code constants: CH_BS, CH_LF, CH_FF, CH_CR
  - BLANK_CHAR default
  - state enum: CLEAR_ALL, IDLE, CLEAR_LINE
- No sub-module. The character RAM is external and is instantiated alongside this block and the glyph renderer.

Test Plan:
- Reset release → 7200 writes of 0x20 to addresses 0..7199 in order; o_ready low throughout, high on the next cycle; cursor (0,0).
- Send 0x41 at cursor (0,0) → one cycle later o_wr_en=1, addr 0, data 0x41; cursor (0,1).
- Send 160 × 0x42 from (0,0):
  - last char write is at addr 159; cursor becomes (1,0).
  - Then 160 writes of 0x20 to addresses 160..319; o_ready low for 160 cycles.
- Backspace cases:
  - BS at col 0 → no o_wr_en, cursor unchanged.
  - Then 'X','Y',BS → BS produces a write of 0x20 to addr 1; cursor (0,1).
- Cursor (44,5), send LF → cursor (0,0); addresses 0..159 cleared; no write to row 44.
- FF at (10,20) → full 7200-write clear, then cursor (0,0). Separately, assert i_rst_n low mid-CLEAR_LINE → o_wr_en=0 immediately; CLEAR_ALL restarts after release.
